// File: rtl/tick_bcd_counter_if.sv
// Avalon-MM slave bus bundle for tick_bcd_counter: register select, write strobe and data, registered read data.
interface tick_bcd_counter_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/tick_bcd_counter.sv
// BCD event counter clocked by rising edges of the interval-timer tick, with Avalon-MM control and wrap interrupt.
// Optional 7-segment decode of each digit is enabled by defining TICK_BCD_COUNTER_SEG_DECODE_EN.
module tick_bcd_counter #(
  parameter int          DIGITS      = 4,
  parameter logic [15:0] RESET_COUNT = 16'h0000
) (
  input  logic                clk,
  input  logic                reset_n,
  tick_bcd_counter_if.slave   bus,
  input  logic                tick,
  output logic                irq,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3
);

  localparam logic [15:0] ACTIVE_MASK  = 16'hFFFF >> (4 * (4 - DIGITS));
  localparam logic [15:0] COUNT_INIT   = RESET_COUNT & ACTIVE_MASK;
  localparam logic [15:0] LIMIT_INIT   = 16'h9999 & ACTIVE_MASK;

  function automatic logic [15:0] clamp_bcd(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < DIGITS) r[4*i +: 4] = (w[4*i +: 4] > 4'd9) ? 4'd9 : w[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] w);
    logic [15:0] r;
    logic        carry;
    r     = '0;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < DIGITS) begin
        if (!carry)                     r[4*i +: 4] = w[4*i +: 4];
        else if (w[4*i +: 4] == 4'd9)   r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = w[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] w);
    logic [15:0] r;
    logic        borrow;
    r      = '0;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < DIGITS) begin
        if (!borrow)                    r[4*i +: 4] = w[4*i +: 4];
        else if (w[4*i +: 4] == 4'd0)   r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = w[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [15:0] count, limit, rd_mux, step_value;
  logic        running, irq_enable, down, wrap_occurred, tick_d;
  logic        wr, wr_status, wr_control, wr_count, wr_limit;
  logic        start_strobe, stop_strobe, clear_strobe;
  logic        tick_event, step, step_wrap, wrap_set;

  always_comb begin
    wr           = bus.chipselect && !bus.write_n;
    wr_status    = wr && (bus.address == 3'd0);
    wr_control   = wr && (bus.address == 3'd1);
    wr_count     = wr && (bus.address == 3'd2);
    wr_limit     = wr && (bus.address == 3'd3);
    start_strobe = wr_control && bus.writedata[2];
    stop_strobe  = wr_control && bus.writedata[3];
    clear_strobe = wr_control && bus.writedata[4];
    tick_event   = tick && !tick_d;
    step         = running && tick_event;

    step_wrap  = 1'b0;
    step_value = count;
    if (!down) begin
      if (count >= limit) begin
        step_value = '0;
        step_wrap  = 1'b1;
      end else begin
        step_value = bcd_inc(count);
      end
    end else begin
      if (count == '0) begin
        step_value = limit;
        step_wrap  = 1'b1;
      end else begin
        step_value = bcd_dec(count);
      end
    end
    // A step pre-empted by clear or load is dropped entirely, including its wrap.
    wrap_set = step && step_wrap && !clear_strobe && !wr_count;

    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux = {14'd0, running, wrap_occurred};
      3'd1:    rd_mux = {14'd0, down, irq_enable};
      3'd2:    rd_mux = count;
      3'd3:    rd_mux = limit;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count         <= COUNT_INIT;
      limit         <= LIMIT_INIT;
      running       <= 1'b0;
      irq_enable    <= 1'b0;
      down          <= 1'b0;
      wrap_occurred <= 1'b0;
      tick_d        <= 1'b0;
      bus.readdata  <= '0;
    end else begin
      tick_d <= tick;
      if (bus.chipselect) bus.readdata <= rd_mux;

      if (wr_control) begin
        irq_enable <= bus.writedata[0];
        down       <= bus.writedata[1];
        if (start_strobe)     running <= 1'b1;
        else if (stop_strobe) running <= 1'b0;
      end

      if (wr_limit) limit <= clamp_bcd(bus.writedata);

      if (clear_strobe)  count <= '0;
      else if (wr_count) count <= clamp_bcd(bus.writedata);
      else if (step)     count <= step_value;

      if (wrap_set)       wrap_occurred <= 1'b1;
      else if (wr_status) wrap_occurred <= 1'b0;
    end
  end

  assign irq = wrap_occurred && irq_enable;

`ifdef TICK_BCD_COUNTER_SEG_DECODE_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [15:0] w, input int idx);
    if (idx >= DIGITS) return 7'h7F;
    return seg7(w[4*idx +: 4]);
  endfunction

  logic [6:0] hex_p1 [4];

  // Decode stage: displays follow the count one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) hex_p1[i] <= digit_seg(COUNT_INIT, i);
    end else begin
      for (int i = 0; i < 4; i++) hex_p1[i] <= digit_seg(count, i);
    end
  end

  assign hex0 = hex_p1[0];
  assign hex1 = hex_p1[1];
  assign hex2 = hex_p1[2];
  assign hex3 = hex_p1[3];
`else
  assign hex0 = 7'h7F;
  assign hex1 = 7'h7F;
  assign hex2 = 7'h7F;
  assign hex3 = 7'h7F;
`endif

endmodule
